// File: rtl/turn_scheduler.sv
// Turn/game-flow controller: alternates player and PC turns, runs the player countdown,
// hands each move to the move-check datapath and records the game result.
module turn_scheduler #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned TURN_SECS     = 15,
    parameter int unsigned MAX_MOVES     = 42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       player_valid,
    input  logic       pc_done,
    input  logic       chk_ack,
    input  logic       chk_win,
    input  logic       chk_full,
    output logic       player_turn,
    output logic       pc_go,
    output logic       chk_req,
    output logic       chk_src,
    output logic [3:0] secs_left,
    output logic       timeout,
    output logic [5:0] move_cnt,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);

    typedef enum logic [2:0] {StIdle, StPlayer, StPc, StCheck, StOver} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    secs_q, secs_d;
    logic          timeout_q, timeout_d;
    logic [5:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]    winner_q, winner_d;
    logic          src_q, src_d;
    logic          tick;

    assign tick    = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        secs_d    = secs_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        src_d     = src_q;
        case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d  = StPlayer;
                    cnt_d    = '0;
                    winner_d = 2'b00;
                    secs_d   = 4'(TURN_SECS);
                    presc_d  = '0;
                end
            end
            StPlayer: begin
                // A committed move beats an expiry tick landing in the same cycle.
                if (player_valid) begin
                    state_d = StCheck;
                    src_d   = 1'b0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (secs_q == 4'd1) begin
                            state_d   = StPc;
                            timeout_d = 1'b1;
                            secs_d    = 4'd0;
                        end else begin
                            secs_d = secs_q - 4'd1;
                        end
                    end
                end
            end
            StPc: begin
                if (pc_done) begin
                    state_d = StCheck;
                    src_d   = 1'b1;
                end
            end
            StCheck: begin
                if (chk_ack) begin
                    cnt_d = cnt_inc;
                    if (chk_win) begin
                        state_d  = StOver;
                        winner_d = src_q ? 2'b10 : 2'b01;
                    end else if (chk_full || (cnt_inc == 6'(MAX_MOVES))) begin
                        state_d  = StOver;
                        winner_d = 2'b11;
                    end else if (src_q) begin
                        state_d = StPlayer;
                        secs_d  = 4'(TURN_SECS);
                        presc_d = '0;
                    end else begin
                        state_d = StPc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            secs_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            winner_q  <= 2'b00;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            secs_q    <= secs_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            src_q     <= src_d;
        end
    end

    assign player_turn = (state_q == StPlayer);
    assign pc_go       = (state_q == StPc);
    assign chk_req     = (state_q == StCheck);
    assign game_over   = (state_q == StOver);
    assign chk_src     = src_q;
    assign secs_left   = secs_q;
    assign timeout     = timeout_q;
    assign move_cnt    = cnt_q;
    assign winner      = winner_q;

endmodule
